// File: rtl/byte_unpacker.sv
// byte_unpacker: splits a byte stream into a nibble stream via a small FIFO.
// Ports: clk, rst_n | in_data/in_valid/in_ready | out_nib/out_valid/out_ready/out_last | fifo_count
module byte_unpacker #(
    parameter int DEPTH      = 4,
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [3:0]               out_nib,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRST  = 2'd1;
    localparam logic [1:0] S_SECOND = 2'd2;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_state;
    logic [7:0]    r_byte;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_fire;
    logic [7:0]    w_head;

    function automatic logic [3:0] f_first(input logic [7:0] b);
        return HIGH_FIRST ? b[7:4] : b[3:0];
    endfunction

    function automatic logic [3:0] f_second(input logic [7:0] b);
        return HIGH_FIRST ? b[3:0] : b[7:4];
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rptr];

    // in_ready depends on the count only: a pop in the same cycle
    // does not open a slot until the next cycle.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_fire   = out_valid && out_ready;

    // Load the output register when idle, or back-to-back when the
    // second nibble of the current byte is being taken.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_SECOND) && w_fire));

    assign out_valid  = (r_state == S_FIRST) || (r_state == S_SECOND);
    assign out_last   = (r_state == S_SECOND);
    assign out_nib    = (r_state == S_SECOND) ? f_second(r_byte)
                                              : f_first(r_byte);
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_byte  <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_byte  <= w_head;
                        r_state <= S_FIRST;
                    end
                end
                S_FIRST: begin
                    if (w_fire) begin
                        r_state <= S_SECOND;
                    end
                end
                S_SECOND: begin
                    if (w_fire) begin
                        if (w_pop) begin
                            r_byte  <= w_head;
                            r_state <= S_FIRST;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_unpacker.sv
// tb_byte_unpacker: random and directed stimulus against a queue-based model.
// Two DUTs share the inputs: HIGH_FIRST=1 and HIGH_FIRST=0.
module tb_byte_unpacker;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [7:0] b_t;
    typedef logic [4:0] n_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;

    logic          hi_in_ready, lo_in_ready;
    logic [3:0]    hi_nib, lo_nib;
    logic          hi_valid, lo_valid;
    logic          hi_last, lo_last;
    logic [CW-1:0] hi_cnt, lo_cnt;

    byte_unpacker #(.DEPTH(DEPTH), .HIGH_FIRST(1'b1)) u_hi (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(hi_in_ready),
        .out_nib(hi_nib), .out_valid(hi_valid), .out_ready(out_ready),
        .out_last(hi_last), .fifo_count(hi_cnt)
    );

    byte_unpacker #(.DEPTH(DEPTH), .HIGH_FIRST(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(lo_in_ready),
        .out_nib(lo_nib), .out_valid(lo_valid), .out_ready(out_ready),
        .out_last(lo_last), .fifo_count(lo_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: bytes waiting in the FIFO, plus the byte in the output
    // register and how many of its nibbles are still to be taken.
    b_t mq[$];
    int hold = 0;
    b_t cur = 8'h00;
    int max_cnt = 0;
    n_t seen_hi[$];
    n_t seen_lo[$];
    int stamp[$];
    int acc_stamp = 0;

    always @(negedge clk) begin : compare
        int cons;
        bit psh;
        if (!rst_n) begin
            mq.delete();
            hold = 0;
            cur  = 8'h00;
            chk("rst_valid_hi", int'(hi_valid), 0);
            chk("rst_valid_lo", int'(lo_valid), 0);
            chk("rst_cnt_hi", int'(hi_cnt), 0);
            chk("rst_last_hi", int'(hi_last), 0);
        end else begin
            chk("valid_hi", int'(hi_valid), int'(hold > 0));
            chk("valid_lo", int'(lo_valid), int'(hold > 0));
            chk("count_hi", int'(hi_cnt), mq.size());
            chk("count_lo", int'(lo_cnt), mq.size());
            chk("in_ready_hi", int'(hi_in_ready), int'(mq.size() < DEPTH));
            chk("in_ready_lo", int'(lo_in_ready), int'(mq.size() < DEPTH));
            if (hold > 0) begin
                chk("nib_hi", int'(hi_nib),
                    (hold == 2) ? int'(cur[7:4]) : int'(cur[3:0]));
                chk("nib_lo", int'(lo_nib),
                    (hold == 2) ? int'(cur[3:0]) : int'(cur[7:4]));
                chk("last_hi", int'(hi_last), int'(hold == 1));
                chk("last_lo", int'(lo_last), int'(hold == 1));
            end
            if (int'(hi_cnt) > max_cnt) max_cnt = int'(hi_cnt);
            if (hi_valid && out_ready) begin
                seen_hi.push_back({hi_last, hi_nib});
                stamp.push_back(cyc + 1);
            end
            if (lo_valid && out_ready) seen_lo.push_back({lo_last, lo_nib});
            if (in_valid && hi_in_ready) acc_stamp = cyc + 1;
            // advance the model across the coming edge
            cons = (hold > 0 && out_ready) ? 1 : 0;
            psh  = in_valid && (mq.size() < DEPTH);
            hold = hold - cons;
            if (hold == 0 && mq.size() > 0) begin
                cur  = mq.pop_front();
                hold = 2;
            end
            if (psh) mq.push_back(in_data);
        end
    end

    task automatic clear_log();
        seen_hi.delete();
        seen_lo.delete();
        stamp.delete();
    endtask

    task automatic offer(input b_t bytes[$], input int max_cyc, output int n_acc);
        bit rdy;
        n_acc = 0;
        for (int c = 0; c < max_cyc && n_acc < bytes.size(); c++) begin
            in_valid = 1'b1;
            in_data  = bytes[n_acc];
            @(negedge clk);
            rdy = hi_in_ready;
            @(posedge clk);
            #1;
            if (rdy) n_acc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((hi_valid || hi_cnt != 0 || lo_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, int'(hi_valid || hi_cnt != 0 || lo_valid), 0);
    endtask

    task automatic chk_seq(input string name, input n_t exp[$], input n_t got[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk(name, int'(got[i]), int'(exp[i]));
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        b_t bq[$];
        n_t eq[$];
        n_t eq2[$];
        int n;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_in_ready", int'(hi_in_ready), 1);
        chk("reset_valid", int'(hi_valid), 0);
        chk("reset_count", int'(hi_cnt), 0);
        chk("reset_nib", int'(hi_nib), 0);
        chk("reset_last", int'(hi_last), 0);
        @(posedge clk);
        #1;

        // single byte A5
        clear_log();
        out_ready = 1'b1;
        bq = {};
        bq.push_back(8'hA5);
        offer(bq, 5, n);
        drain("a5_drain");
        eq = {}; eq.push_back(5'h0A); eq.push_back(5'h15);
        chk_seq("a5_hi", eq, seen_hi);
        eq = {}; eq.push_back(5'h05); eq.push_back(5'h1A);
        chk_seq("a5_lo", eq, seen_lo);
        if (stamp.size() == 2) begin
            chk("a5_latency", stamp[0] - acc_stamp, 2);
            chk("a5_gap", stamp[1] - stamp[0], 1);
        end else begin
            chk("a5_stamps", stamp.size(), 2);
        end

        // back-to-back 12 34 56
        clear_log();
        bq = {};
        bq.push_back(8'h12); bq.push_back(8'h34); bq.push_back(8'h56);
        offer(bq, 10, n);
        drain("b2b_drain");
        eq = {};
        for (int i = 1; i <= 6; i++) eq.push_back(n_t'(((i % 2 == 0) ? 16 : 0) + i));
        chk_seq("b2b", eq, seen_hi);
        if (stamp.size() == 6) chk("b2b_span", stamp[5] - stamp[0], 5);
        else chk("b2b_stamps", stamp.size(), 6);

        // backpressure
        clear_log();
        out_ready = 1'b0;
        bq = {};
        for (int i = 1; i <= 7; i++) bq.push_back(b_t'(i * 8'h11));
        offer(bq, 12, n);
        chk("bp_accepted", n, 5);
        chk("bp_in_ready", int'(hi_in_ready), 0);
        chk("bp_count", int'(hi_cnt), 4);
        chk("bp_nib", int'(hi_nib), 1);
        chk("bp_valid", int'(hi_valid), 1);
        drain("bp_drain");
        eq = {};
        for (int i = 1; i <= 5; i++) begin
            eq.push_back(n_t'(i));
            eq.push_back(n_t'(16 + i));
        end
        chk_seq("bp", eq, seen_hi);

        // wrap-around with toggling out_ready
        clear_log();
        max_cnt = 0;
        out_ready = 1'b0;
        bq = {};
        for (int i = 0; i < 10; i++) bq.push_back(b_t'(i));
        fork
            offer(bq, 60, n);
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1 out_ready = ~out_ready;
                end
            end
        join
        drain("wrap_drain");
        chk("wrap_accepted", n, 10);
        chk("wrap_max_le4", int'(max_cnt <= 4), 1);
        eq = {};
        eq2 = {};
        for (int i = 0; i < 10; i++) begin
            eq.push_back(5'h00);
            eq.push_back(n_t'(16 + i));
            eq2.push_back(n_t'(i));
            eq2.push_back(5'h10);
        end
        chk_seq("wrap_hi", eq, seen_hi);
        chk_seq("wrap_lo", eq2, seen_lo);

        // random traffic
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 800; k++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = b_t'($urandom);
                out_ready = (ph == 0) ? ($urandom_range(0, 3) != 0)
                          : (ph == 1) ? ($urandom_range(0, 3) == 0)
                          : ($urandom_range(0, 1) == 1);
                @(posedge clk);
                #1;
            end
        end
        drain("rand_drain");

        // reset during output
        clear_log();
        out_ready = 1'b0;
        bq = {};
        bq.push_back(8'hC3); bq.push_back(8'h77);
        offer(bq, 6, n);
        chk("rst_pre_nib", int'(hi_nib), 'hC);
        chk("rst_pre_count", int'(hi_cnt), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid_hi", int'(hi_valid), 0);
        chk("async_valid_lo", int'(lo_valid), 0);
        chk("async_count", int'(hi_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_nib_after_reset", seen_hi.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/byte_unpacker.md
Name: byte_unpacker

Overview:
- Converts a stream of 8-bit bytes into a stream of 4-bit nibbles. It is the inverse of the nibble-to-byte packing used on the adder datapath, where the byte is formed as {upper nibble, lower nibble}.
- Input bytes pass through a small FIFO. An output serializer then emits two nibbles per byte, each under a valid/ready handshake.
- The block sits between byte-wide producers and the 4-bit adder and display paths.

Parameters:
- DEPTH, 4: input FIFO entries. Must be a power of 2, at least 2.
- HIGH_FIRST, 1: 1 = emit bits [7:4] then [3:0]; 0 = emit bits [3:0] then [7:4].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  byte to unpack.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a byte.
- out_nib  output  4  current nibble.
- out_valid  output  1  out_nib is valid.
- out_ready  input  1  consumer accepts out_nib.
- out_last  output  1  out_nib is the second nibble of its byte.
- fifo_count  output  $clog2(DEPTH)+1  bytes held in the FIFO. Excludes the byte in the output register.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous): FIFO pointers = 0, fifo_count = 0, out_valid = 0, out_nib = 4'h0, out_last = 0, FSM = IDLE. in_ready = 1 once the FIFO is empty. Reset asserted mid-operation discards all buffered bytes and any partially emitted byte. No nibble is emitted after reset release until a new byte is accepted.
- Input handshake: a byte is accepted on a clk edge where in_valid && in_ready. in_ready = !fifo_full and is combinational from fifo_count only. There is no pass-through on full: a simultaneous pop does not raise in_ready in the same cycle.
- FIFO: circular buffer with write pointer and read pointer. Both pointers wrap modulo DEPTH. Push and pop in the same cycle leave fifo_count unchanged. A push is ignored when full, which cannot occur because in_ready is 0. A pop never occurs when empty.
- Output register: holds one byte (cur_byte) plus the FSM state.
- FSM states:
  - IDLE: out_valid = 0. If the FIFO is non-empty, pop into cur_byte and go to FIRST.
  - FIRST: out_valid = 1, out_last = 0, out_nib = first nibble. On out_valid && out_ready, go to SECOND.
  - SECOND: out_valid = 1, out_last = 1, out_nib = second nibble. On out_valid && out_ready:
    - If the FIFO is non-empty, pop into cur_byte and go to FIRST in the same edge, with no bubble.
    - Otherwise go to IDLE.
- Outputs are registered. out_nib, out_valid and out_last change only on clk edges.
- Stability: while out_valid = 1 and out_ready = 0, out_nib and out_last hold stable.
- Latency: a byte accepted into an empty block at edge N pops at edge N+1. out_valid rises after edge N+1, giving 1 cycle in the FIFO plus 1 cycle to load.
- Throughput: with out_ready held at 1, one nibble is emitted per cycle, i.e. one byte per 2 cycles. Sustained input at that rate never fills the FIFO.
- Total buffering: DEPTH bytes in the FIFO plus 1 byte in the output register.
- Nibble selection:
  - HIGH_FIRST = 1: first = cur_byte[7:4], second = cur_byte[3:0].
  - HIGH_FIRST = 0: the two nibbles are swapped.
- No arithmetic is performed on the data. Pointer increments wrap naturally at log2(DEPTH) bits.

Test Plan:
- Reset, then push 8'hA5 with out_ready = 1:
  - out_valid rises 2 cycles after acceptance.
  - out_nib = 4'hA (out_last = 0), then 4'h5 (out_last = 1).
  - out_valid = 0 on the following cycle.
- Back-to-back bytes 8'h12, 8'h34, 8'h56 with out_ready = 1 -> out_nib sequence 1,2,3,4,5,6 on consecutive cycles, with out_last high on 2, 4 and 6.
- Backpressure: with out_ready = 0, offer bytes 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 and further bytes (DEPTH = 4):
  - Exactly 5 bytes are accepted; in_ready = 0 and fifo_count = 4 afterwards.
  - out_nib holds 4'h1 steady.
  - Raising out_ready drains the nibbles 1,1,2,2,...,5,5 in order.
- Wrap-around: stream 10 bytes 8'h00..8'h09 with out_ready toggling every other cycle -> all 20 nibbles appear in order, and fifo_count never exceeds 4.
- HIGH_FIRST = 0, push 8'hA5 -> 4'h5 (out_last = 0), then 4'hA (out_last = 1).
- Push 8'hC3 and pulse rst_n low while out_nib = 4'hC is presented:
  - out_valid drops immediately (asynchronously) and fifo_count = 0.
  - No 4'h3 is ever emitted.
